priority_decoder_24_seq: RTL

//  - Sequential counterpart of the 4:2 priority encoder: accepts its {a,b,v} code, registers it, drives one-hot y[3:0].
//  - y is held for at least HOLD_CYCLES cycles, then released by a valid/ready handshake with the consumer.
//  - Sits downstream of the encoder in lab designs (LED/strobe drive, grant lines, channel select).

---
 rtl/priority_decoder_24_seq_if.sv | 42 ++++
 rtl/priority_decoder_24_seq.sv | 144 ++++++++++++++
 2 files changed

// File: rtl/priority_decoder_24_seq_if.sv
// Code/decode bus between the 4:2 encoder, the sequential decoder and its consumer.
// Counter select/readback signals exist only when PDEC_EVENT_COUNT_EN is defined.
interface priority_decoder_24_seq_if #(
  parameter int CNT_W = 8
) ();
  logic             a;
  logic             b;
  logic             v;
  logic             in_ready;
  logic [3:0]       y;
  logic             y_valid;
  logic             y_ready;
  logic             busy;
`ifdef PDEC_EVENT_COUNT_EN
  logic [1:0]       cnt_sel;
  logic [CNT_W-1:0] cnt_value;

  modport master (
    output a, b, v, y_ready, cnt_sel,
    input  in_ready, y, y_valid, busy, cnt_value
  );

  modport slave (
    input  a, b, v, y_ready, cnt_sel,
    output in_ready, y, y_valid, busy, cnt_value
  );
`else
  if (CNT_W < 1) begin : g_cnt_w_check
    $error("CNT_W must be at least 1");
  end

  modport master (
    output a, b, v, y_ready,
    input  in_ready, y, y_valid, busy
  );

  modport slave (
    input  a, b, v, y_ready,
    output in_ready, y, y_valid, busy
  );
`endif
endinterface

// File: rtl/priority_decoder_24_seq.sv
// Sequential 2:4 decoder: registers an encoder {a,b} code, holds one-hot y for HOLD_CYCLES,
// then releases on a valid/ready handshake. Optional per-channel counters: PDEC_EVENT_COUNT_EN.
module priority_decoder_24_seq #(
  parameter int HOLD_CYCLES = 4,
  parameter int CNT_W       = 8
) (
  input logic                    clk,
  input logic                    rst,
  priority_decoder_24_seq_if.slave bus
);

  localparam int              HC_W      = $clog2(HOLD_CYCLES) + 1;
  localparam logic [HC_W-1:0] HOLD_LOAD = HC_W'(HOLD_CYCLES - 1);

  if (HOLD_CYCLES < 1 || CNT_W < 1) begin : g_param_check
    $error("HOLD_CYCLES and CNT_W must be at least 1");
  end

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    HOLD = 1'b1
  } state_t;

  function automatic logic [3:0] decode_onehot(input logic [1:0] code);
    logic [3:0] onehot;
    case (code)
      2'd0:    onehot = 4'b0001;
      2'd1:    onehot = 4'b0010;
      2'd2:    onehot = 4'b0100;
      2'd3:    onehot = 4'b1000;
      default: onehot = 4'b0000;
    endcase
    return onehot;
  endfunction

  state_t          state_r;
  state_t          state_nxt_s;
  logic [HC_W-1:0] hold_cnt_r;
  logic [HC_W-1:0] hold_cnt_nxt_s;
  logic [3:0]      y_r;
  logic [3:0]      y_nxt_s;
  logic            y_valid_r;
  logic            y_valid_nxt_s;
  logic            in_ready_r;
  logic            busy_r;

  // State and output registers; outputs are derived from the next state so they never lag it.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= IDLE;
      hold_cnt_r <= '0;
      y_r        <= 4'b0000;
      y_valid_r  <= 1'b0;
      in_ready_r <= 1'b1;
      busy_r     <= 1'b0;
    end else begin
      state_r    <= state_nxt_s;
      hold_cnt_r <= hold_cnt_nxt_s;
      y_r        <= y_nxt_s;
      y_valid_r  <= y_valid_nxt_s;
      in_ready_r <= (state_nxt_s == IDLE);
      busy_r     <= (state_nxt_s != IDLE);
    end
  end

  // Next-state logic: accept in IDLE, count down in HOLD, release only once the hold has expired.
  always_comb begin
    state_nxt_s    = state_r;
    hold_cnt_nxt_s = hold_cnt_r;
    y_nxt_s        = y_r;
    y_valid_nxt_s  = y_valid_r;
    case (state_r)
      IDLE: begin
        if (bus.v) begin
          state_nxt_s    = HOLD;
          hold_cnt_nxt_s = HOLD_LOAD;
          y_nxt_s        = decode_onehot({bus.a, bus.b});
          y_valid_nxt_s  = 1'b1;
        end else begin
          hold_cnt_nxt_s = '0;
          y_nxt_s        = 4'b0000;
          y_valid_nxt_s  = 1'b0;
        end
      end
      HOLD: begin
        if (hold_cnt_r != '0) begin
          hold_cnt_nxt_s = hold_cnt_r - 1'b1;
        end else if (bus.y_ready) begin
          state_nxt_s   = IDLE;
          y_nxt_s       = 4'b0000;
          y_valid_nxt_s = 1'b0;
        end else begin
          hold_cnt_nxt_s = '0;
        end
      end
      default: begin
        state_nxt_s    = IDLE;
        hold_cnt_nxt_s = '0;
        y_nxt_s        = 4'b0000;
        y_valid_nxt_s  = 1'b0;
      end
    endcase
  end

  assign bus.y        = y_r;
  assign bus.y_valid  = y_valid_r;
  assign bus.in_ready = in_ready_r;
  assign bus.busy     = busy_r;

`ifdef PDEC_EVENT_COUNT_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] val);
    logic [CNT_W-1:0] res;
    if (val == {CNT_W{1'b1}}) begin
      res = val;
    end else begin
      res = val + 1'b1;
    end
    return res;
  endfunction

  logic             accept_s;
  logic [1:0]       code_s;
  logic [CNT_W-1:0] cnt_r [4];

  assign accept_s = bus.v & (state_r == IDLE);
  assign code_s   = {bus.a, bus.b};

  // Per-channel accepted-code counters, saturating, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < 4; i++) begin
        cnt_r[i] <= '0;
      end
    end else if (accept_s) begin
      cnt_r[code_s] <= sat_inc(cnt_r[code_s]);
    end else begin
      cnt_r[code_s] <= cnt_r[code_s];
    end
  end

  assign bus.cnt_value = cnt_r[bus.cnt_sel];
`endif

endmodule
